// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter between single-cycle ALU and multi-cycle MUL/DIV results,
// with a pending-destination scoreboard. Define REGFILE_WB_RR_EN for round-robin conflict policy.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rdi,
  input  logic [31:0] alu_rd,
  output logic        alu_ready,
  input  logic        md_valid,
  input  logic [4:0]  md_rdi,
  input  logic [31:0] md_rd,
  output logic        md_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rdi,
  output logic        iss_ready,
  input  logic [4:0]  rsi1,
  input  logic [4:0]  rsi2,
  output logic        hazard,
  output logic [4:0]  rdi,
  output logic [31:0] rd,
  output logic        write_enable,
  output logic [31:0] pending
);

  logic [31:0] pending_q, pending_d;
  logic [4:0]  rdi_q, rdi_d;
  logic [31:0] rd_q, rd_d;
  logic        we_q, we_d;
  logic        alu_stall, conflict, md_wins;
  logic        alu_fire, md_fire, iss_fire;

`ifdef REGFILE_WB_RR_EN
  typedef enum logic {GRANT_ALU, GRANT_MD} grant_e;
  grant_e last_grant_q, last_grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= GRANT_ALU;
    else        last_grant_q <= last_grant_d;
  end

  // A conflict always completes a transfer for the winner, so the grant can advance unconditionally.
  always_comb begin
    last_grant_d = last_grant_q;
    if (conflict) last_grant_d = md_wins ? GRANT_MD : GRANT_ALU;
  end

  assign md_wins = (last_grant_q == GRANT_ALU);
`else
  assign md_wins = 1'b1;
`endif

  always_comb begin
    alu_stall = (alu_rdi != '0) && pending_q[alu_rdi];
    conflict  = md_valid && alu_valid && !alu_stall;
    alu_ready = !alu_stall && !(conflict && md_wins);
    md_ready  = !(conflict && !md_wins);
    iss_ready = !((iss_rdi != '0) && pending_q[iss_rdi]);
    hazard    = ((rsi1 != '0) && pending_q[rsi1]) || ((rsi2 != '0) && pending_q[rsi2]);
  end

  assign alu_fire = alu_valid && alu_ready;
  assign md_fire  = md_valid && md_ready;
  assign iss_fire = iss_valid && iss_ready;

  always_comb begin
    we_d  = 1'b0;
    rdi_d = rdi_q;
    rd_d  = rd_q;
    if (md_fire) begin
      we_d  = (md_rdi != '0);
      rdi_d = md_rdi;
      rd_d  = md_rd;
    end else if (alu_fire) begin
      we_d  = (alu_rdi != '0);
      rdi_d = alu_rdi;
      rd_d  = alu_rd;
    end
  end

  // Clear before set: a fresh issue to an index being retired leaves it reserved.
  always_comb begin
    pending_d = pending_q;
    if (md_fire) pending_d[md_rdi] = 1'b0;
    if (iss_fire && (iss_rdi != '0)) pending_d[iss_rdi] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      rdi_q     <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rdi_q     <= rdi_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
    end
  end

  assign pending      = pending_q;
  assign rdi          = rdi_q;
  assign rd           = rd_q;
  assign write_enable = we_q;

endmodule
